// File: rtl/tsp_filter_ram.sv
// tsp_filter_ram: MPEG-TS PID filter.
// - Monitor filters capture one packet of a programmed PID for host readback.
// - Replacer filters substitute a host-loaded packet into the output stream.
// - A word-addressed host port gives access to the registers and packet buffers.
//
// Host handshake: a write is accepted in every cycle where wen=1, with byte
// lanes selected by wstrb. A read is requested with ren=1, and rdata carries
// the addressed word after the next clk edge. rdata holds while ren=0.
// There is no back-pressure on either path.
module tsp_filter_ram #(
    parameter int C_S_AXI_DATA_WIDTH  = 32,
    parameter int OPT_MEM_ADDR_BITS   = 10,
    parameter int MONITOR_FILTER_NUM  = 2,
    parameter int REPLACER_FILTER_NUM = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] wstrb,
    input  logic                            wen,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   wdata,
    input  logic [OPT_MEM_ADDR_BITS:0]      waddr,
    input  logic                            ren,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   rdata,
    input  logic [OPT_MEM_ADDR_BITS:0]      raddr,
    input  logic [7:0]                      mpeg_data,
    input  logic                            mpeg_valid,
    input  logic                            mpeg_sync,
    output logic                            ts_out_clk,
    output logic                            ts_out_valid,
    output logic                            ts_out_sync,
    output logic [7:0]                      ts_out
);

    localparam int NF        = MONITOR_FILTER_NUM + REPLACER_FILTER_NUM;
    localparam int FW        = (NF > 1) ? $clog2(NF) : 1;
    localparam int AW        = OPT_MEM_ADDR_BITS + 1;
    localparam int PKT_WORDS = 47;
    localparam int WIN_BASE  = 128;
    localparam int MEM_WORDS = NF * PKT_WORDS;
    localparam int MAW       = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // between packets, bytes without sync are ignored
        ST_HDR  = 2'd1,   // bytes 0..1 seen, PID not yet known
        ST_BODY = 2'd2    // PID resolved, bytes 3..187
    } state_t;

    // Buffer word index of word w inside filter f's packet buffer.
    function automatic logic [MAW-1:0] word_addr(input int f, input int w);
        return MAW'(f * PKT_WORDS + w);
    endfunction

    // Merge new_v into old_v on the enabled byte lanes.
    function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int l = 0; l < 4; l++) begin
            if (strb[l]) res[8*l +: 8] = new_v[8*l +: 8];
        end
        return res;
    endfunction

    // ---------------- host-visible registers ----------------
    logic [31:0]   index_q, index_d;
    logic [31:0]   pidx_q, pidx_d;
    logic [12:0]   pid_q [NF];
    logic [12:0]   pid_d [NF];
    logic [NF-1:0] pid_en_q, pid_en_d;
    logic [NF-1:0] match_en_q, match_en_d;
    logic [NF-1:0] ready_q, ready_d;
    logic [NF-1:0] armed_q, armed_d;
    logic [31:0]   rdata_q, rd_val;

    // ---------------- stream state ----------------
    state_t          st_q, st_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [7:0]      cur_idx;
    logic [7:0]      hold0_q, hold0_d;
    logic [7:0]      hold1_q, hold1_d;
    logic            rep_act_q, rep_act_d;
    logic [FW-1:0]   rep_sel_q, rep_sel_d;
    logic            cap_act_q, cap_act_d;
    logic [FW-1:0]   cap_sel_q, cap_sel_d;
    logic            take_byte, hdr_byte1, resolve, body_byte, last_byte;

    logic [12:0]     stream_pid;
    logic [NF-1:0]   active;
    logic            cap_hit, rep_hit;
    logic [FW-1:0]   cap_hit_sel, rep_hit_sel;

    // ---------------- packet buffers ----------------
    logic [3:0][7:0] mem_q [MEM_WORDS];
    logic            host_mem_we;
    logic [MAW-1:0]  host_mem_addr;
    logic            cap_we;
    logic [MAW-1:0]  cap_addr;
    logic [3:0]      cap_lanes;
    logic [3:0][7:0] cap_data;
    logic [MAW-1:0]  rep_addr;
    logic [7:0]      rep_byte, out_byte;

    logic            ts_valid_q, ts_sync_q;
    logic [7:0]      ts_q;

    logic            sel_ok, sel_is_mon, w_in_win, r_in_win;
    logic [FW-1:0]   sel;

    // Decode the INDEX selection and the data-window hits for both host ports.
    always_comb begin
        sel_ok        = index_q < 32'(NF);
        sel           = index_q[FW-1:0];
        sel_is_mon    = int'(sel) < MONITOR_FILTER_NUM;
        w_in_win      = (waddr >= AW'(WIN_BASE)) && (waddr < AW'(WIN_BASE + PKT_WORDS));
        r_in_win      = (raddr >= AW'(WIN_BASE)) && (raddr < AW'(WIN_BASE + PKT_WORDS));
        host_mem_we   = wen && w_in_win && sel_ok;
        host_mem_addr = word_addr(int'(sel), int'(waddr) - WIN_BASE);
    end

    // Next state of the host registers, including capture completion.
    always_comb begin
        index_d    = index_q;
        pidx_d     = pidx_q;
        pid_d      = pid_q;
        pid_en_d   = pid_en_q;
        match_en_d = match_en_q;
        ready_d    = ready_q;
        armed_d    = armed_q;
        if (wen) begin
            if (waddr == AW'(0)) index_d = apply_strb(index_q, wdata, wstrb);
            if (waddr == AW'(1)) pidx_d  = apply_strb(pidx_q, wdata, wstrb);
            if (sel_ok) begin
                if (waddr == AW'(2)) begin
                    if (wstrb[0]) pid_d[sel][7:0]  = wdata[7:0];
                    if (wstrb[1]) pid_d[sel][12:8] = wdata[12:8];
                    if (wstrb[2]) pid_en_d[sel]    = wdata[16];
                end
                if (waddr == AW'(3) && wstrb[0]) match_en_d[sel] = wdata[0];
                if (waddr == AW'(4) && (|wstrb)) begin
                    if (sel_is_mon) begin
                        ready_d[sel] = 1'b0;
                        armed_d[sel] = 1'b1;
                    end else begin
                        ready_d[sel] = 1'b1;
                    end
                end
            end
        end
        // Capture finishing on byte 187 publishes the buffer and disarms.
        if (last_byte && cap_act_q) begin
            ready_d[cap_sel_q] = 1'b1;
            armed_d[cap_sel_q] = 1'b0;
        end
    end

    // Host register state with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            index_q    <= '0;
            pidx_q     <= '0;
            pid_en_q   <= '0;
            match_en_q <= '0;
            ready_q    <= '0;
            armed_q    <= '0;
            for (int f = 0; f < NF; f++) pid_q[f] <= '0;
        end else begin
            index_q    <= index_d;
            pidx_q     <= pidx_d;
            pid_q      <= pid_d;
            pid_en_q   <= pid_en_d;
            match_en_q <= match_en_d;
            ready_q    <= ready_d;
            armed_q    <= armed_d;
        end
    end

    // Host read multiplexer; out-of-range INDEX and unmapped addresses read 0.
    always_comb begin
        rd_val = '0;
        if (raddr == AW'(0)) begin
            rd_val = index_q;
        end else if (raddr == AW'(1)) begin
            rd_val = pidx_q;
        end else if (sel_ok) begin
            if (raddr == AW'(2)) begin
                rd_val = {15'b0, pid_en_q[sel], 3'b0, pid_q[sel]};
            end else if (raddr == AW'(3)) begin
                rd_val = {31'b0, match_en_q[sel]};
            end else if (raddr == AW'(4)) begin
                rd_val = {31'b0, ready_q[sel]};
            end else if (r_in_win) begin
                rd_val = mem_q[word_addr(int'(sel), int'(raddr) - WIN_BASE)];
            end
        end
    end

    // Registered read data, held while ren is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (ren) begin
            rdata_q <= rd_val;
        end
    end

    // Stream FSM: state register.
    always_ff @(posedge clk) begin
        if (!rst_n) st_q <= ST_IDLE;
        else        st_q <= st_d;
    end

    // Stream FSM: next state. A sync always restarts the packet, which is
    // also how a short packet aborts capture and replacement.
    always_comb begin
        st_d = st_q;
        if (mpeg_valid) begin
            if (mpeg_sync) begin
                st_d = ST_HDR;
            end else begin
                case (st_q)
                    ST_HDR:  if (cnt_q == 8'd1)   st_d = ST_BODY;
                    ST_BODY: if (cnt_q == 8'd186) st_d = ST_IDLE;
                    default: st_d = st_q;
                endcase
            end
        end
    end

    // Stream FSM: outputs, the per-byte strobes used by the datapath.
    always_comb begin
        cur_idx   = mpeg_sync ? 8'd0 : cnt_q + 8'd1;
        take_byte = mpeg_valid && (mpeg_sync || st_q != ST_IDLE);
        hdr_byte1 = mpeg_valid && !mpeg_sync && st_q == ST_HDR && cnt_q == 8'd0;
        resolve   = mpeg_valid && !mpeg_sync && st_q == ST_HDR && cnt_q == 8'd1;
        body_byte = mpeg_valid && !mpeg_sync && st_q == ST_BODY;
        last_byte = body_byte && cnt_q == 8'd186;
    end

    // PID match; the lowest-index candidate wins in each filter group.
    always_comb begin
        stream_pid  = {hold1_q[4:0], mpeg_data};
        cap_hit     = 1'b0;
        cap_hit_sel = '0;
        rep_hit     = 1'b0;
        rep_hit_sel = '0;
        for (int f = 0; f < NF; f++) begin
            active[f] = match_en_q[f] && pid_en_q[f] && (pid_q[f] == stream_pid);
        end
        for (int f = MONITOR_FILTER_NUM - 1; f >= 0; f--) begin
            if (active[f] && armed_q[f]) begin
                cap_hit     = 1'b1;
                cap_hit_sel = FW'(f);
            end
        end
        for (int f = NF - 1; f >= MONITOR_FILTER_NUM; f--) begin
            if (active[f]) begin
                rep_hit     = 1'b1;
                rep_hit_sel = FW'(f);
            end
        end
    end

    // Byte counter, header holding registers and per-packet filter decision.
    always_comb begin
        cnt_d     = cnt_q;
        hold0_d   = hold0_q;
        hold1_d   = hold1_q;
        rep_act_d = rep_act_q;
        rep_sel_d = rep_sel_q;
        cap_act_d = cap_act_q;
        cap_sel_d = cap_sel_q;
        if (take_byte) cnt_d = cur_idx;
        if (mpeg_valid && mpeg_sync) begin
            hold0_d   = mpeg_data;
            rep_act_d = 1'b0;
            cap_act_d = 1'b0;
        end
        if (hdr_byte1) hold1_d = mpeg_data;
        if (resolve) begin
            rep_act_d = rep_hit;
            rep_sel_d = rep_hit_sel;
            cap_act_d = cap_hit;
            cap_sel_d = cap_hit_sel;
        end
        if (last_byte) begin
            rep_act_d = 1'b0;
            cap_act_d = 1'b0;
        end
    end

    // Stream datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            hold0_q   <= '0;
            hold1_q   <= '0;
            rep_act_q <= 1'b0;
            rep_sel_q <= '0;
            cap_act_q <= 1'b0;
            cap_sel_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            hold0_q   <= hold0_d;
            hold1_q   <= hold1_d;
            rep_act_q <= rep_act_d;
            rep_sel_q <= rep_sel_d;
            cap_act_q <= cap_act_d;
            cap_sel_q <= cap_sel_d;
        end
    end

    // Capture write port: header bytes 0..2 land together when the PID
    // resolves, then one byte per body byte.
    always_comb begin
        cap_we    = 1'b0;
        cap_addr  = '0;
        cap_lanes = '0;
        cap_data  = '0;
        if (resolve && cap_hit) begin
            cap_we    = 1'b1;
            cap_addr  = word_addr(int'(cap_hit_sel), 0);
            cap_lanes = 4'b0111;
            cap_data  = {mpeg_data, mpeg_data, hold1_q, hold0_q};
        end else if (body_byte && cap_act_q) begin
            cap_we    = 1'b1;
            cap_addr  = word_addr(int'(cap_sel_q), int'(cur_idx[7:2]));
            cap_lanes = 4'b0001 << cur_idx[1:0];
            cap_data  = {4{mpeg_data}};
        end
    end

    // Packet buffers; capture is written last so it wins a same-lane clash.
    always_ff @(posedge clk) begin
        if (host_mem_we) begin
            for (int l = 0; l < 4; l++) begin
                if (wstrb[l]) mem_q[host_mem_addr][l] <= wdata[8*l +: 8];
            end
        end
        if (cap_we) begin
            for (int l = 0; l < 4; l++) begin
                if (cap_lanes[l]) mem_q[cap_addr][l] <= cap_data[l];
            end
        end
    end

    // Select the replacement byte for the current body position.
    always_comb begin
        rep_addr = word_addr(int'(rep_sel_q), int'(cur_idx[7:2]));
        rep_byte = mem_q[rep_addr][cur_idx[1:0]];
        out_byte = (body_byte && rep_act_q) ? rep_byte : mpeg_data;
    end

    // Output stream register, one cycle behind the input byte.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts_valid_q <= 1'b0;
            ts_sync_q  <= 1'b0;
            ts_q       <= '0;
        end else begin
            ts_valid_q <= mpeg_valid;
            ts_sync_q  <= mpeg_valid & mpeg_sync;
            if (mpeg_valid) ts_q <= out_byte;
        end
    end

    assign rdata        = rdata_q;
    assign ts_out_clk   = clk;
    assign ts_out_valid = ts_valid_q;
    assign ts_out_sync  = ts_sync_q;
    assign ts_out       = ts_q;

endmodule

// File: tb/tb_tsp_filter_ram.sv
// Testbench for tsp_filter_ram: register table, packet replacement,
// capture, truncated-packet abort and mid-packet reset.
module tb_tsp_filter_ram;

    typedef struct {
        bit          is_wr;
        logic [10:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } reg_vec_t;

    localparam int NVEC = 25;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  wstrb;
    logic        wen;
    logic [31:0] wdata;
    logic [10:0] waddr;
    logic        ren;
    logic [31:0] rdata;
    logic [10:0] raddr;
    logic [7:0]  mpeg_data;
    logic        mpeg_valid;
    logic        mpeg_sync;
    logic        ts_out_clk;
    logic        ts_out_valid;
    logic        ts_out_sync;
    logic [7:0]  ts_out;

    int total = 0;
    int bad   = 0;

    logic [7:0]  pkt_in  [188];
    logic [7:0]  pkt_exp [188];
    reg_vec_t    vecs [NVEC];

    tsp_filter_ram dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wstrb        (wstrb),
        .wen          (wen),
        .wdata        (wdata),
        .waddr        (waddr),
        .ren          (ren),
        .rdata        (rdata),
        .raddr        (raddr),
        .mpeg_data    (mpeg_data),
        .mpeg_valid   (mpeg_valid),
        .mpeg_sync    (mpeg_sync),
        .ts_out_clk   (ts_out_clk),
        .ts_out_valid (ts_out_valid),
        .ts_out_sync  (ts_out_sync),
        .ts_out       (ts_out)
    );

    // Clock
    always #5 clk = ~clk;

    // Scoreboard compare
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference patterns for replacer buffers
    function automatic logic [7:0] pat(input int which, input int n);
        if (which == 0) return 8'((n * 5 + 17) & 255);
        return 8'(255 - n);
    endfunction

    // Reference TS packet byte n for a given PID and payload seed
    function automatic logic [7:0] pkt_byte(input logic [12:0] pid, input int seed, input int n);
        if (n == 0) return 8'h47;
        if (n == 1) return {3'b010, pid[12:8]};
        if (n == 2) return pid[7:0];
        return 8'((n * 7 + seed * 13) & 255);
    endfunction

    // Expected buffer byte: mode 0/1 = pattern, 2 = captured packet
    function automatic logic [7:0] buf_byte(input int mode, input logic [12:0] pid,
                                            input int seed, input int n);
        if (mode == 2) return pkt_byte(pid, seed, n);
        return pat(mode, n);
    endfunction

    // Driver: host write (entered and left at posedge+1)
    task automatic wr(input logic [10:0] a, input logic [31:0] d, input logic [3:0] s);
        wen = 1'b1; waddr = a; wdata = d; wstrb = s;
        @(posedge clk); #1;
        wen = 1'b0; wstrb = 4'h0;
    endtask

    // Driver: host read
    task automatic rd(input logic [10:0] a, output logic [31:0] d);
        ren = 1'b1; raddr = a;
        @(posedge clk); #1;
        ren = 1'b0;
        d = rdata;
    endtask

    task automatic rd_check(input string name, input logic [10:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        check(name, d, exp);
    endtask

    // Load a replacer buffer with a pattern
    task automatic load_pat(input int idx, input int which);
        wr(11'd0, 32'(idx), 4'hF);
        for (int w = 0; w < 47; w++) begin
            wr(11'(128 + w), {pat(which, 4*w+3), pat(which, 4*w+2),
                              pat(which, 4*w+1), pat(which, 4*w)}, 4'hF);
        end
    endtask

    // Read back all 47 words of filter idx and compare against the model
    task automatic check_buf(input string name, input int idx, input int mode,
                             input logic [12:0] pid, input int seed);
        logic [31:0] d;
        wr(11'd0, 32'(idx), 4'hF);
        for (int w = 0; w < 47; w++) begin
            rd(11'(128 + w), d);
            check($sformatf("%s_w%0d", name, w), d,
                  {buf_byte(mode, pid, seed, 4*w+3), buf_byte(mode, pid, seed, 4*w+2),
                   buf_byte(mode, pid, seed, 4*w+1), buf_byte(mode, pid, seed, 4*w)});
        end
    endtask

    // Build input packet and expected output; rep < 0 means pass-through
    task automatic prep(input logic [12:0] pid, input int seed, input int rep);
        for (int n = 0; n < 188; n++) begin
            pkt_in[n]  = pkt_byte(pid, seed, n);
            pkt_exp[n] = (rep >= 0 && n >= 3) ? pat(rep, n) : pkt_in[n];
        end
    endtask

    // Driver + checker: stream len bytes back to back, compare each output
    task automatic run_packet(input int len, input string name);
        int nbad;
        int first;
        nbad  = 0;
        first = -1;
        for (int n = 0; n < len; n++) begin
            mpeg_valid = 1'b1;
            mpeg_sync  = (n == 0);
            mpeg_data  = pkt_in[n];
            @(posedge clk); #1;
            if (ts_out_valid !== 1'b1 || ts_out_sync !== 1'(n == 0) || ts_out !== pkt_exp[n]) begin
                nbad++;
                if (first < 0) first = n;
            end
        end
        mpeg_valid = 1'b0;
        mpeg_sync  = 1'b0;
        mpeg_data  = 8'h00;
        check({name, "_bytes"}, 32'(nbad), 32'd0);
        if (first >= 0) $display("  %s first bad byte index %0d", name, first);
        @(posedge clk); #1;
        check({name, "_idle"}, {30'b0, ts_out_valid, ts_out_sync}, 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        rst_n = 1'b0; wen = 1'b0; ren = 1'b0; wstrb = 4'h0; wdata = '0;
        waddr = '0; raddr = '0; mpeg_data = '0; mpeg_valid = 1'b0; mpeg_sync = 1'b0;

        // Register vector table: {is_wr, addr, data, strb, expected read}
        vecs[0]  = '{1'b0, 11'd0,   32'h0,        4'h0, 32'h0};
        vecs[1]  = '{1'b0, 11'd2,   32'h0,        4'h0, 32'h0};
        vecs[2]  = '{1'b0, 11'd4,   32'h0,        4'h0, 32'h0};
        vecs[3]  = '{1'b1, 11'd0,   32'h2,        4'hF, 32'h0};
        vecs[4]  = '{1'b1, 11'd2,   32'h0001157f, 4'hF, 32'h0};
        vecs[5]  = '{1'b0, 11'd2,   32'h0,        4'h0, 32'h0001157f};
        vecs[6]  = '{1'b1, 11'd2,   32'h00000011, 4'h1, 32'h0};
        vecs[7]  = '{1'b0, 11'd2,   32'h0,        4'h0, 32'h00011511};
        vecs[8]  = '{1'b1, 11'd2,   32'h0001157f, 4'hF, 32'h0};
        vecs[9]  = '{1'b1, 11'd3,   32'h1,        4'hF, 32'h0};
        vecs[10] = '{1'b0, 11'd3,   32'h0,        4'h0, 32'h1};
        vecs[11] = '{1'b1, 11'd1,   32'hdeadbeef, 4'h3, 32'h0};
        vecs[12] = '{1'b0, 11'd1,   32'h0,        4'h0, 32'h0000beef};
        vecs[13] = '{1'b1, 11'd0,   32'h7,        4'hF, 32'h0};
        vecs[14] = '{1'b1, 11'd3,   32'h0,        4'hF, 32'h0};
        vecs[15] = '{1'b0, 11'd3,   32'h0,        4'h0, 32'h0};
        vecs[16] = '{1'b0, 11'd2,   32'h0,        4'h0, 32'h0};
        vecs[17] = '{1'b0, 11'd0,   32'h0,        4'h0, 32'h7};
        vecs[18] = '{1'b0, 11'd200, 32'h0,        4'h0, 32'h0};
        vecs[19] = '{1'b1, 11'd0,   32'h2,        4'hF, 32'h0};
        vecs[20] = '{1'b0, 11'd3,   32'h0,        4'h0, 32'h1};
        vecs[21] = '{1'b1, 11'd0,   32'h00000100, 4'h2, 32'h0};
        vecs[22] = '{1'b0, 11'd0,   32'h0,        4'h0, 32'h00000102};
        vecs[23] = '{1'b0, 11'd130, 32'h0,        4'h0, 32'h0};
        vecs[24] = '{1'b1, 11'd0,   32'h2,        4'hF, 32'h0};

        // Reset
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_ts_out", {24'b0, ts_out}, 32'h0);
        check("rst_ts_valid", {31'b0, ts_out_valid}, 32'h0);
        check("rst_ts_sync", {31'b0, ts_out_sync}, 32'h0);
        check("rst_rdata", rdata, 32'h0);

        // Register table
        for (int i = 0; i < NVEC; i++) begin
            if (vecs[i].is_wr) begin
                wr(vecs[i].addr, vecs[i].data, vecs[i].strb);
            end else begin
                rd(vecs[i].addr, d);
                check($sformatf("vec%0d_addr%0d", i, vecs[i].addr), d, vecs[i].exp);
            end
        end

        // rdata holds while ren is low
        rd(11'd1, d);
        raddr = 11'd0;
        repeat (2) @(posedge clk);
        #1 check("rdata_hold", rdata, 32'h0000beef);

        // Replacer 2 (PID 0x157f, enabled by the table) with pattern A
        load_pat(2, 0);
        prep(13'h157f, 1, 0);
        run_packet(188, "replace_a");

        // Non-matching PID passes through
        prep(13'h0191, 2, -1);
        run_packet(188, "pass_0191");

        // Replacer READ_REQUEST is ready at once; buffer reads back
        wr(11'd0, 32'd2, 4'hF);
        rd_check("rep2_ready_pre", 11'd4, 32'h0);
        wr(11'd4, 32'h1234, 4'hF);
        rd_check("rep2_ready_post", 11'd4, 32'h1);
        check_buf("rep2_buf", 2, 0, 13'h0, 0);

        // Monitor 0 capture of PID 0x0191
        wr(11'd0, 32'd0, 4'hF);
        wr(11'd2, 32'h00010191, 4'hF);
        wr(11'd3, 32'h1, 4'hF);
        wr(11'd4, 32'h0, 4'hF);
        rd_check("mon0_ready_pre", 11'd4, 32'h0);
        prep(13'h0191, 20, -1);
        run_packet(188, "mon0_pkt");
        rd_check("mon0_ready_post", 11'd4, 32'h1);
        check_buf("mon0_buf", 0, 2, 13'h0191, 20);
        rd(11'd128, d);
        check("mon0_sync_byte", {24'b0, d[7:0]}, 32'h47);

        // Disarmed monitor does not overwrite its buffer
        prep(13'h0191, 30, -1);
        run_packet(188, "mon0_second");
        check_buf("mon0_keep", 0, 2, 13'h0191, 20);

        // Monitor 1: truncated packet aborts, next full packet is captured
        wr(11'd0, 32'd1, 4'hF);
        wr(11'd2, 32'h00010200, 4'hF);
        wr(11'd3, 32'h1, 4'hF);
        wr(11'd4, 32'h0, 4'hF);
        prep(13'h0200, 3, -1);
        run_packet(100, "mon1_trunc");
        rd_check("mon1_ready_trunc", 11'd4, 32'h0);
        prep(13'h0200, 9, -1);
        run_packet(188, "mon1_full");
        rd_check("mon1_ready_full", 11'd4, 32'h1);
        check_buf("mon1_buf", 1, 2, 13'h0200, 9);

        // Two replacers on one PID: lowest index wins, then the other
        load_pat(3, 1);
        wr(11'd2, 32'h0001157f, 4'hF);
        wr(11'd3, 32'h1, 4'hF);
        prep(13'h157f, 40, 0);
        run_packet(188, "rep_lowest");
        wr(11'd0, 32'd2, 4'hF);
        wr(11'd3, 32'h0, 4'hF);
        prep(13'h157f, 41, 1);
        run_packet(188, "rep_second");

        // Host writes into a monitor buffer, full and partial
        wr(11'd0, 32'd1, 4'hF);
        wr(11'd133, 32'h11223344, 4'hF);
        rd_check("host_buf_full", 11'd133, 32'h11223344);
        wr(11'd133, 32'hAAAAAAAA, 4'h4);
        rd_check("host_buf_strb", 11'd133, 32'h11AA3344);

        // Reset in the middle of a replaced packet
        wr(11'd0, 32'd3, 4'hF);
        rd_check("pre_rst_pid", 11'd2, 32'h0001157f);
        prep(13'h157f, 50, 1);
        for (int n = 0; n < 50; n++) begin
            mpeg_valid = 1'b1;
            mpeg_sync  = (n == 0);
            mpeg_data  = pkt_in[n];
            @(posedge clk); #1;
        end
        mpeg_data = pkt_in[50];
        mpeg_sync = 1'b0;
        rst_n     = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_ts_out", {24'b0, ts_out}, 32'h0);
        check("mid_rst_valid", {31'b0, ts_out_valid}, 32'h0);
        check("mid_rst_sync", {31'b0, ts_out_sync}, 32'h0);
        check("mid_rst_rdata", rdata, 32'h0);
        mpeg_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        rd_check("post_rst_index", 11'd0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            wr(11'd0, 32'(i), 4'hF);
            rd_check($sformatf("post_rst_ready%0d", i), 11'd4, 32'h0);
        end
        rd_check("post_rst_pid3", 11'd2, 32'h0);
        prep(13'h157f, 60, -1);
        run_packet(188, "post_rst_pass");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
